// File: rtl/huffman_load_ctrl.sv
// Load controller for one Huffman decompression job: streams bitstream words
// MSB-first into the decoder wrapper and writes each decoded row to activation SRAM.
module huffman_load_ctrl #(
  parameter int col           = 8,
  parameter int bw            = 8,
  parameter int WORD_W        = 32,
  parameter int BS_ADDR_W     = 10,
  parameter int ROW_ADDR_W    = 11,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BS_ADDR_W:0]      num_words,
  input  logic [ROW_ADDR_W:0]     num_rows,
  output logic                    bs_cen,
  output logic [BS_ADDR_W-1:0]    bs_addr,
  input  logic [WORD_W-1:0]       bs_q,
  output logic                    dec_reset,
  output logic                    dec_data_in,
  output logic                    dec_data_valid,
  input  logic [col*bw-1:0]       dec_row,
  input  logic                    dec_row_valid,
  output logic                    sram_cen,
  output logic                    sram_wen,
  output logic [ROW_ADDR_W-1:0]   sram_addr,
  output logic [col*bw-1:0]       sram_d,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam int BIT_W  = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_LATCH, S_SHIFT, S_DRAIN, S_DONE
  } state_t;

  state_t state, next_state;

  logic [BS_ADDR_W:0]  num_words_q, word_cnt, word_cnt_inc;
  logic [ROW_ADDR_W:0] num_rows_q, row_cnt;
  logic [WORD_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [IDLE_W-1:0]   idle_cnt;

  logic job_start, last_bit, rows_complete, drain_timeout;
  logic capture_active, row_accept, row_overrun;

  assign job_start      = (state == S_IDLE) && start;
  assign last_bit       = (bit_cnt == BIT_W'(WORD_W - 1));
  assign word_cnt_inc   = word_cnt + 1'b1;
  assign rows_complete  = (row_cnt == num_rows_q);
  assign drain_timeout  = (state == S_DRAIN) && !rows_complete &&
                          (idle_cnt == IDLE_W'(DRAIN_TIMEOUT - 1));
  assign capture_active = (state != S_IDLE) && (state != S_DONE);
  assign row_accept     = capture_active && dec_row_valid && (row_cnt < num_rows_q);
  assign row_overrun    = capture_active && dec_row_valid && (row_cnt >= num_rows_q);

  // The read address tracks the word counter; it only matters while bs_cen is low.
  assign bs_addr     = word_cnt[BS_ADDR_W-1:0];
  assign dec_data_in = shreg[WORD_W-1];

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      S_IDLE:  if (start) next_state = S_CLR;
      S_CLR: begin
        if (num_words_q != '0)     next_state = S_FETCH;
        else if (num_rows_q != '0) next_state = S_DRAIN;
        else                       next_state = S_DONE;
      end
      S_FETCH: next_state = S_LATCH;
      S_LATCH: next_state = S_SHIFT;
      S_SHIFT: begin
        if (last_bit) next_state = (word_cnt_inc < num_words_q) ? S_FETCH : S_DRAIN;
      end
      S_DRAIN: begin
        if (rows_complete || drain_timeout) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_words_q <= '0;
      num_rows_q  <= '0;
      word_cnt    <= '0;
      row_cnt     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
    end else begin
      if (job_start) begin
        num_words_q <= num_words;
        num_rows_q  <= num_rows;
        word_cnt    <= '0;
        row_cnt     <= '0;
      end else begin
        if (state == S_SHIFT && last_bit) word_cnt <= word_cnt_inc;
        if (row_accept)                   row_cnt  <= row_cnt + 1'b1;
      end

      if (state == S_LATCH) begin
        shreg   <= bs_q;
        bit_cnt <= '0;
      end else if (state == S_SHIFT) begin
        shreg   <= {shreg[WORD_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Idle time is measured only while draining; any row restarts the window.
      if (state != S_DRAIN || dec_row_valid) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bs_cen         <= 1'b1;
      dec_reset      <= 1'b0;
      dec_data_valid <= 1'b0;
      sram_cen       <= 1'b1;
      sram_wen       <= 1'b1;
      sram_addr      <= '0;
      sram_d         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      // Control strobes are decoded from next_state so they line up with the state itself.
      bs_cen         <= (next_state != S_FETCH);
      dec_reset      <= (next_state == S_CLR);
      dec_data_valid <= (next_state == S_SHIFT);
      busy           <= (next_state != S_IDLE) && (next_state != S_DONE);
      done           <= (next_state == S_DONE);

      sram_cen <= !row_accept;
      sram_wen <= !row_accept;
      if (row_accept) begin
        sram_addr <= row_cnt[ROW_ADDR_W-1:0];
        sram_d    <= dec_row;
      end

      if (job_start) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end else begin
        if (drain_timeout) err_timeout <= 1'b1;
        if (row_overrun)   err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_huffman_load_ctrl.sv
// Directed bench for huffman_load_ctrl: bitstream SRAM model, scripted decoder rows,
// and negedge monitors logging every serial bit, fetch, row write and strobe.
module tb_huffman_load_ctrl;

  localparam int COL = 8, BW = 8, WORD_W = 32, BS_ADDR_W = 10, ROW_ADDR_W = 11;
  localparam int ROW_W = COL * BW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [BS_ADDR_W:0]    num_words;
  logic [ROW_ADDR_W:0]   num_rows;
  logic                  bs_cen;
  logic [BS_ADDR_W-1:0]  bs_addr;
  logic [WORD_W-1:0]     bs_q;
  logic                  dec_reset, dec_data_in, dec_data_valid;
  logic [ROW_W-1:0]      dec_row;
  logic                  dec_row_valid;
  logic                  sram_cen, sram_wen;
  logic [ROW_ADDR_W-1:0] sram_addr;
  logic [ROW_W-1:0]      sram_d;
  logic                  busy, done, err_timeout, err_overrun;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  huffman_load_ctrl dut (
    .clk(clk), .reset(rst), .start(start), .num_words(num_words), .num_rows(num_rows),
    .bs_cen(bs_cen), .bs_addr(bs_addr), .bs_q(bs_q),
    .dec_reset(dec_reset), .dec_data_in(dec_data_in), .dec_data_valid(dec_data_valid),
    .dec_row(dec_row), .dec_row_valid(dec_row_valid),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  logic [WORD_W-1:0] bs_mem [0:3];
  initial begin
    bs_mem[0] = 32'hA5A5_0000;
    bs_mem[1] = 32'hFFFF_0001;
    bs_mem[2] = 32'h0;
    bs_mem[3] = 32'h0;
    bs_q      = '0;
  end
  always @(posedge clk) if (!bs_cen) bs_q <= bs_mem[bs_addr[1:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             bit_val[$];
  int               bit_cyc[$];
  int               fetch_addr[$];
  int               wr_addr[$];
  logic [ROW_W-1:0] wr_data[$];
  int               wr_cyc[$];
  int done_cnt = 0, done_cyc = 0, dres_cnt = 0, dres_cyc = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (dec_data_valid) begin
      bit_val.push_back(dec_data_in);
      bit_cyc.push_back(cyc);
    end
    if (!bs_cen) fetch_addr.push_back(int'(bs_addr));
    if (!sram_cen && !sram_wen) begin
      wr_addr.push_back(int'(sram_addr));
      wr_data.push_back(sram_d);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dec_reset) begin
      dres_cnt++;
      dres_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  int b_bits, b_fetch, b_wr, b_done, b_dres, b_busy;

  task automatic mark();
    b_bits  = bit_val.size();
    b_fetch = fetch_addr.size();
    b_wr    = wr_addr.size();
    b_done  = done_cnt;
    b_dres  = dres_cnt;
    b_busy  = busy_cnt;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] row_data(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i + 1) * 64'h0000_0101_0101_0101);
  endfunction

  function automatic logic [9:0] status_vec();
    return {bs_cen, sram_cen, sram_wen, dec_reset, dec_data_valid, dec_data_in,
            busy, done, err_timeout, err_overrun};
  endfunction

  // Issues a start, emits up to three rows at the given cycle offsets from the start
  // cycle, optionally re-pulses start at busy_off, and runs span cycles in total.
  task automatic run_job(input int nw, input int nr, input int o0, input int o1, input int o2,
                         input int n_emit, input int busy_off, input int span, output int s);
    int offs[3];
    int ei;
    offs[0] = o0; offs[1] = o1; offs[2] = o2;
    ei = 0;
    mark();
    s = cyc;
    start = 1'b1;
    num_words = (BS_ADDR_W+1)'(nw);
    num_rows  = (ROW_ADDR_W+1)'(nr);
    for (int k = 1; k <= span; k++) begin
      tick();
      start = (k == busy_off);
      dec_row_valid = 1'b0;
      if (ei < n_emit && k == offs[ei]) begin
        dec_row_valid = 1'b1;
        dec_row = row_data(ei);
        ei++;
      end
    end
    start = 1'b0;
    dec_row_valid = 1'b0;
    tick();
  endtask

  task automatic check_writes(input string tag, input int s, input int n,
                              input int k0, input int k1, input int k2);
    int ks[3];
    ks[0] = k0; ks[1] = k1; ks[2] = k2;
    check({tag, "_wr_count"}, 64'(wr_addr.size() - b_wr), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (b_wr + i < wr_addr.size()) begin
        check($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_addr[b_wr+i]), 64'(i));
        check($sformatf("%s_wr%0d_data", tag, i), wr_data[b_wr+i], row_data(i));
        check($sformatf("%s_wr%0d_cyc", tag, i), 64'(wr_cyc[b_wr+i]), 64'(s + ks[i] + 1));
      end
    end
  endtask

  initial begin
    int s;
    logic [63:0] bits;

    rst = 1'b1;
    start = 1'b0;
    num_words = '0;
    num_rows = '0;
    dec_row = '0;
    dec_row_valid = 1'b0;
    repeat (3) tick();
    check("reset_status", 64'(status_vec()), 64'(10'b1110000000));
    check("reset_bs_addr", 64'(bs_addr), 64'd0);
    check("reset_sram_addr_d", 64'(sram_addr) | sram_d, 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of shifting word 0.
    mark();
    s = cyc;
    start = 1'b1;
    num_words = 11'd2;
    num_rows = 12'd1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_rst_shifting", 64'({dec_data_valid, busy}), 64'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_status", 64'(status_vec()), 64'(10'b1110000000));
    check("mid_rst_bs_addr", 64'(bs_addr), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("mid_rst_no_done", 64'(done_cnt - b_done), 64'd0);

    // Two words, three rows: one during SHIFT, two back-to-back in DRAIN.
    run_job(2, 3, 10, 75, 76, 3, 0, 100, s);
    check("j2_bit_count", 64'(bit_val.size() - b_bits), 64'd64);
    bits = '0;
    for (int i = 0; i < 64; i++)
      if (b_bits + i < bit_val.size()) bits = {bits[62:0], bit_val[b_bits+i]};
    check("j2_bits", bits, 64'hA5A5_0000_FFFF_0001);
    if (bit_val.size() - b_bits >= 64) begin
      check("j2_first_bit_cyc", 64'(bit_cyc[b_bits]), 64'(s + 4));
      check("j2_bubble", 64'(bit_cyc[b_bits+32] - bit_cyc[b_bits+31]), 64'd3);
    end
    check("j2_fetch_count", 64'(fetch_addr.size() - b_fetch), 64'd2);
    if (fetch_addr.size() - b_fetch >= 2) begin
      check("j2_fetch0_addr", 64'(fetch_addr[b_fetch]), 64'd0);
      check("j2_fetch1_addr", 64'(fetch_addr[b_fetch+1]), 64'd1);
    end
    check_writes("j2", s, 3, 10, 75, 76);
    check("j2_dec_reset", 64'({dres_cnt - b_dres, dres_cyc}), 64'({1, s + 1}));
    check("j2_done_count", 64'(done_cnt - b_done), 64'd1);
    check("j2_done_cyc", 64'(done_cyc), 64'(s + 78));
    check("j2_busy_cycles", 64'(busy_cnt - b_busy), 64'd77);
    check("j2_errors", 64'({err_timeout, err_overrun}), 64'd0);

    // Overrun: two rows expected, three delivered back-to-back.
    run_job(0, 2, 2, 3, 4, 3, 0, 20, s);
    check_writes("ovr", s, 2, 2, 3, 0);
    check("ovr_done_count", 64'(done_cnt - b_done), 64'd1);
    check("ovr_done_cyc", 64'(done_cyc), 64'(s + 5));
    check("ovr_busy_cycles", 64'(busy_cnt - b_busy), 64'd4);
    check("ovr_errors_sticky", 64'({err_timeout, err_overrun}), 64'b01);
    check("ovr_no_fetch", 64'(fetch_addr.size() - b_fetch), 64'd0);

    // Timeout: four rows expected, two delivered; start re-pulsed while busy.
    run_job(0, 4, 2, 3, 0, 2, 30, 80, s);
    check_writes("tmo", s, 2, 2, 3, 0);
    check("tmo_done_count", 64'(done_cnt - b_done), 64'd1);
    check("tmo_done_cyc", 64'(done_cyc), 64'(s + 68));
    check("tmo_busy_cycles", 64'(busy_cnt - b_busy), 64'd67);
    check("tmo_errors", 64'({err_timeout, err_overrun}), 64'b10);

    // Empty job; start held into CLR must not launch a second job.
    run_job(0, 0, 0, 0, 0, 0, 1, 10, s);
    check("empty_done_count", 64'(done_cnt - b_done), 64'd1);
    check("empty_done_cyc", 64'(done_cyc), 64'(s + 2));
    check("empty_busy_cycles", 64'(busy_cnt - b_busy), 64'd1);
    check("empty_dec_reset_cyc", 64'(dres_cyc), 64'(s + 1));
    check("empty_no_sram", 64'((wr_addr.size() - b_wr) + (fetch_addr.size() - b_fetch)), 64'd0);
    check("empty_errors", 64'({err_timeout, err_overrun}), 64'd0);

    // A row strobe while idle is ignored.
    mark();
    dec_row_valid = 1'b1;
    dec_row = row_data(7);
    tick();
    dec_row_valid = 1'b0;
    repeat (3) tick();
    check("idle_row_no_write", 64'(wr_addr.size() - b_wr), 64'd0);
    check("idle_row_no_error", 64'({err_timeout, err_overrun, busy}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huffman_load_ctrl.md
Name: huffman_load_ctrl

Overview:
- Sequences one decompression job: fetches compressed words from the bitstream SRAM and serializes them MSB-first into the Huffman wrapper's 1-bit input.
- Captures each assembled col*bw row the wrapper emits and writes it to the activation SRAM at consecutive addresses.
- Tracks job completion and reports timeout and overrun errors.
- Sits between the host/sequencer (start/done) and the wrapper plus the two SRAMs.

Parameters:
col, 8, decoded values per row
bw, 8, bits per decoded value
WORD_W, 32, bitstream SRAM word width
BS_ADDR_W, 10, bitstream SRAM address width
ROW_ADDR_W, 11, activation SRAM address width
DRAIN_TIMEOUT, 64, max idle cycles allowed in DRAIN

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
num_words  in  BS_ADDR_W+1  compressed words in job; latched at start
num_rows  in  ROW_ADDR_W+1  rows expected; latched at start
bs_cen  out  1  bitstream SRAM chip enable, active-low
bs_addr  out  BS_ADDR_W  bitstream read address
bs_q  in  WORD_W  bitstream read data; valid 1 cycle after bs_cen low
dec_reset  out  1  wrapper synchronous clear, 1-cycle pulse
dec_data_in  out  1  serial bit to wrapper
dec_data_valid  out  1  serial bit qualifier
dec_row  in  col*bw  assembled row from wrapper
dec_row_valid  in  1  row-valid pulse from wrapper
sram_cen  out  1  activation SRAM enable, active-low
sram_wen  out  1  activation SRAM write enable, active-low
sram_addr  out  ROW_ADDR_W  row write address
sram_d  out  col*bw  row write data
busy  out  1  high from the cycle after accepted start until DONE
done  out  1  1-cycle completion pulse
err_timeout  out  1  sticky; cleared by next accepted start
err_overrun  out  1  sticky; cleared by next accepted start

Behaviour:
- Reset values (async, all registered outputs): bs_cen=1, sram_cen=1, sram_wen=1, dec_reset=0, dec_data_valid=0, dec_data_in=0, bs_addr=0, sram_addr=0, sram_d=0, busy=0, done=0, err_*=0, state=IDLE.
- States:
  - IDLE: on start, latch num_words/num_rows, clear word_cnt, row_cnt and err_*, then go to CLR.
  - CLR: dec_reset=1 for exactly one cycle. Next state is FETCH if num_words!=0; else DRAIN if num_rows!=0; else DONE.
  - FETCH: bs_cen=0, bs_addr=word_cnt; go to LATCH.
  - LATCH: load shift register from bs_q, bit_cnt=0; go to SHIFT.
  - SHIFT: each cycle drive dec_data_valid=1 and dec_data_in=shreg[WORD_W-1], then shift left and increment bit_cnt.
    - On bit_cnt==WORD_W-1, increment word_cnt.
    - If word_cnt+1 < num_words, go to FETCH; else go to DRAIN.
    - This gives a 2-cycle bubble between words: dec_data_valid=0 in FETCH and LATCH.
  - DRAIN: idle counter increments each cycle and resets on dec_row_valid.
    - If row_cnt==num_rows, go to DONE.
    - Else if idle counter reaches DRAIN_TIMEOUT-1, set err_timeout and go to DONE.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Row capture (active in CLR through DRAIN): on dec_row_valid with row_cnt<num_rows, the next cycle drives sram_cen=0, sram_wen=0, sram_addr=row_cnt[ROW_ADDR_W-1:0], sram_d=dec_row; row_cnt increments. Write latency is 1 cycle. Rows are written back-to-back if valids are consecutive.
- Overrun: dec_row_valid with row_cnt==num_rows → no write, err_overrun=1.
- Rows arriving in SHIFT are written normally; the job only completes in DRAIN. A dec_row_valid in the same cycle that DRAIN evaluates row_cnt==num_rows-1 is written, and DONE follows one cycle later.
- dec_row_valid in IDLE or DONE is ignored with no error.
- start while busy is ignored. Async reset mid-job aborts immediately to IDLE with no done pulse.
- Counters: word_cnt is BS_ADDR_W+1 bits, row_cnt is ROW_ADDR_W+1 bits, idle counter is clog2(DRAIN_TIMEOUT)+1 bits. No wrap occurs within a legal job.

Test Plan:
- Reset asserted mid-SHIFT → all outputs return to reset values immediately, no done; a new start runs normally.
- Job with num_words=2, bs words 0xA5A5_0000/0xFFFF_0001 → 64 valid bits MSB-first, bubble of 2 cycles between words, bs_addr 0 then 1.
- Wrapper model emits 3 rows (num_rows=3) → sram writes to addr 0,1,2 with matching data, each 1 cycle after dec_row_valid; done pulses once; err_* stay 0.
- num_rows=2 and model emits 3 rows → only 2 writes, err_overrun=1, done still pulses.
- num_rows=4 and model emits 2 rows → 64 idle DRAIN cycles, then err_timeout=1 and done pulse.
- num_words=0, num_rows=0 → CLR then DONE; done 2 cycles after start, no SRAM activity; start pulsed during busy is ignored.
